// File: rtl/sap_pkg.sv
// Shared constants for the SAP controller: opcodes, ALU function codes,
// one-hot T-states and control-word bit positions.
package sap_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // ALU function select, also decoded by the ALU stage.
   typedef enum logic [1:0] {
      SU_ADD = 2'b00,
      SU_SUB = 2'b01,
      SU_AND = 2'b10,
      SU_OR  = 2'b11
   } su_t;

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   localparam int CW_W  = 12;
   localparam int CW_CP = 0;
   localparam int CW_EP = 1;
   localparam int CW_LM = 2;
   localparam int CW_CE = 3;
   localparam int CW_LI = 4;
   localparam int CW_EI = 5;
   localparam int CW_LA = 6;
   localparam int CW_EA = 7;
   localparam int CW_EU = 8;
   localparam int CW_LB = 9;
   localparam int CW_LO = 10;
   localparam int CW_HL = 11;

   function automatic logic is_alu_op(input logic [3:0] opc);
      return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
   endfunction

   function automatic su_t alu_code(input logic [3:0] opc);
      case (opc)
         OP_SUB:  return SU_SUB;
         OP_AND:  return SU_AND;
         OP_OR:   return SU_OR;
         default: return SU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// Six-state one-hot ring counter sequencing T1..T6; freezes while hold is high.
module sap_ring_counter
   import sap_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       hold,
   output logic [5:0] ring
);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         ring <= T1;
      end else if (!hold) begin
         ring <= {ring[4:0], ring[5]};
      end
   end

endmodule

// File: rtl/sap_controller.sv
// SAP controller-sequencer: ring counter plus opcode/T-state decode into the
// bus control word, with a sticky halt flag cleared only by clr.
module sap_controller
   import sap_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           clr,
   input  logic [OPW-1:0] op,
   output logic           cp,
   output logic           ep,
   output logic           lm,
   output logic           ce,
   output logic           li,
   output logic           ei,
   output logic           la,
   output logic           ea,
   output logic [1:0]     su,
   output logic           eu,
   output logic           lb,
   output logic           lo,
   output logic           hlt,
   output logic [2:0]     tstate
);

   logic [5:0]      ring;
   logic            halted;
   logic            halt_now;
   logic [3:0]      opc;
   logic [CW_W-1:0] cw;
   su_t             su_sel;

   assign opc      = 4'(op);
   assign halt_now = (ring == T4) && (opc == OP_HLT);

   // The ring must not leave T4 on the same edge that sets the halt flag.
   sap_ring_counter u_ring (
      .clk  (clk),
      .clr  (clr),
      .hold (halted | halt_now),
      .ring (ring)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         halted <= 1'b0;
      end else if (halt_now) begin
         halted <= 1'b1;
      end
   end

   always_comb begin
      cw     = '0;
      su_sel = SU_ADD;
      if (halted) begin
         cw[CW_HL] = 1'b1;
      end else begin
         unique case (ring)
            T1: begin
               cw[CW_EP] = 1'b1;
               cw[CW_LM] = 1'b1;
            end
            T2: cw[CW_CP] = 1'b1;
            T3: begin
               cw[CW_CE] = 1'b1;
               cw[CW_LI] = 1'b1;
            end
            T4: begin
               if (opc == OP_LDA || is_alu_op(opc)) begin
                  cw[CW_EI] = 1'b1;
                  cw[CW_LM] = 1'b1;
               end else if (opc == OP_OUT) begin
                  cw[CW_EA] = 1'b1;
                  cw[CW_LO] = 1'b1;
               end
            end
            T5: begin
               if (opc == OP_LDA) begin
                  cw[CW_CE] = 1'b1;
                  cw[CW_LA] = 1'b1;
               end else if (is_alu_op(opc)) begin
                  cw[CW_CE] = 1'b1;
                  cw[CW_LB] = 1'b1;
               end
            end
            T6: begin
               if (is_alu_op(opc)) begin
                  cw[CW_EU] = 1'b1;
                  cw[CW_LA] = 1'b1;
               end
            end
            default: cw = '0;
         endcase
         // su stays fixed across T4-T6 so the ALU has settled before eu.
         if (is_alu_op(opc) && (ring == T4 || ring == T5 || ring == T6)) begin
            su_sel = alu_code(opc);
         end
      end
   end

   always_comb begin
      tstate = 3'd1;
      unique case (ring)
         T1:      tstate = 3'd1;
         T2:      tstate = 3'd2;
         T3:      tstate = 3'd3;
         T4:      tstate = 3'd4;
         T5:      tstate = 3'd5;
         T6:      tstate = 3'd6;
         default: tstate = 3'd1;
      endcase
   end

   assign cp  = cw[CW_CP];
   assign ep  = cw[CW_EP];
   assign lm  = cw[CW_LM];
   assign ce  = cw[CW_CE];
   assign li  = cw[CW_LI];
   assign ei  = cw[CW_EI];
   assign la  = cw[CW_LA];
   assign ea  = cw[CW_EA];
   assign eu  = cw[CW_EU];
   assign lb  = cw[CW_LB];
   assign lo  = cw[CW_LO];
   assign hlt = cw[CW_HL];
   assign su  = su_sel;

endmodule
